// File: rtl/usr_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Optional feature macro: USR_DESER_PARITY_EN (adds one even-parity bit per frame).
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

`ifdef USR_DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/usr_deser_shift.sv
// Shift stage: shift register, bit counter, dir latch, parity accumulator.
// Ports: clock/reset, flush, accept+ser_in+dir in; word, perr, bit_cnt, frame_done out.
// Macro USR_DESER_PARITY_EN: last frame bit is parity, not shifted into sh.
import usr_pkg::*;

module usr_deser_shift #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             accept,
  input  logic             ser_in,
  input  logic             dir,
  output logic [WIDTH-1:0] word,
  output logic             perr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  localparam int FRAME = WIDTH + PAR_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic             dir_q;
  logic             dir_eff;
  logic             first;
  logic             data_bit;

  assign first      = (bit_cnt == '0);
  assign dir_eff    = first ? dir : dir_q;
  assign frame_done = accept && (bit_cnt == LAST);

`ifdef USR_DESER_PARITY_EN
  assign data_bit = accept && !frame_done;
`else
  assign data_bit = accept;
`endif

  always_comb begin
    sh_nxt = sh;
    if (data_bit) begin
      if (dir_eff == DIR_MSB_FIRST)
        sh_nxt = {sh[WIDTH-2:0], ser_in};
      else
        sh_nxt = {ser_in, sh[WIDTH-1:1]};
    end
  end

  // Word as it will stand after this edge; valid for loading on frame_done
  // and while the shift stage holds a pending word.
  assign word = sh_nxt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sh      <= '0;
      bit_cnt <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else if (flush) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sh <= sh_nxt;
      if (first)
        dir_q <= dir;
      bit_cnt <= frame_done ? '0 : bit_cnt + 1'b1;
    end
  end

`ifdef USR_DESER_PARITY_EN
  logic par_acc;
  logic perr_q;

  assign perr = frame_done ? (ser_in ^ par_acc) : perr_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else if (flush) begin
      par_acc <= 1'b0;
    end else begin
      if (data_bit)
        par_acc <= (first ? 1'b0 : par_acc) ^ ser_in;
      if (frame_done)
        perr_q <= perr;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver with a one-deep valid/ready output register.
// Ports: clock, reset (sync, active-low), ser_* in, out_* port, dir, flush, bit_cnt.
// Macro USR_DESER_PARITY_EN enables the even-parity bit and out_perr.
import usr_pkg::*;

module usr_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             dir,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             busy;
  logic             load;
  logic             frame_done;
  logic [WIDTH-1:0] word;
  logic             perr;

  assign ser_ready = (state != FULL);
  // A bit offered during flush is dropped.
  assign accept    = ser_valid && ser_ready && !flush;
  assign busy      = out_valid && !out_ready;

  usr_deser_shift #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_shift (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .accept    (accept),
    .ser_in    (ser_in),
    .dir       (dir),
    .word      (word),
    .perr      (perr),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        FULL: begin
          if (out_ready) begin
            state_nxt = IDLE;
            load      = 1'b1;
          end
        end
        default: begin
          if (frame_done) begin
            if (busy) begin
              state_nxt = FULL;
            end else begin
              state_nxt = IDLE;
              load      = 1'b1;
            end
          end else if (accept) begin
            state_nxt = COLLECT;
          end
        end
      endcase
    end
  end

  // Output handshake completes even in a flush cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
    end else if (load) begin
      out_data  <= word;
      out_valid <= 1'b1;
      out_perr  <= perr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
